register_address_pointer: RTL and testbench
===========================================

Name: register_address_pointer

Overview:
Parametrised register-address pointer for the serial-slave front end of the PWM IO expander. It tracks transfer framing (start, address byte, data bytes, stop) and loads the first byte of each transfer as the register address. It auto-advances the pointer per data byte in one of three modes: fixed, linear wrap, or bank wrap. It issues registered write strobes to the register file and flags out-of-range accesses.

Parameters:
ADDR_WIDTH, 8, pointer width in bits; 1..8.
REG_COUNT, 32, number of implemented registers; valid addresses 0..REG_COUNT-1; 2..2^ADDR_WIDTH.
BANK_SIZE, 8, bank-wrap window size; power of 2, 2..REG_COUNT.

Ports:
CLK  in  1  clock, rising edge.
_RST  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse: start or repeated start detected.
stop  in  1  one-cycle pulse: stop detected.
byte_valid  in  1  one-cycle pulse: received byte present on byte_data.
byte_data  in  8  received byte.
rd_ack  in  1  one-cycle pulse: master acknowledged a read byte; advance pointer.
mode  in  2  00 fixed, 01 linear, 10 bank, 11 treated as fixed.
addr  out  ADDR_WIDTH  current pointer; register-file read address.
wr_en  out  1  one-cycle write strobe.
wr_addr  out  ADDR_WIDTH  write address, valid with wr_en.
wr_data  out  8  write data, valid with wr_en.
addr_err  out  1  sticky: an out-of-range address was loaded or reached in this transfer.
busy  out  1  high in ADDR or DATA state.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; addr=0; wr_en=0; wr_addr=0; wr_data=0; addr_err=0; busy=0.
- States: IDLE, ADDR (waiting for address byte), DATA.
- Transitions:
  - start in any state -> ADDR; addr_err cleared; pointer retained.
  - stop in ADDR or DATA -> IDLE; pointer retained.
  - byte_valid in ADDR -> DATA.
  - byte_valid and rd_ack in IDLE are ignored.
- Priority on the same cycle: start > stop > byte_valid > rd_ack. The lower-priority events are dropped.
- Address load, byte_valid in ADDR:
  - addr <= byte_data[ADDR_WIDTH-1:0].
  - addr_err <= 1 if the full 8-bit byte_data >= REG_COUNT.
  - No write strobe.
- Write, byte_valid in DATA, at the same edge:
  - wr_addr <= addr; wr_data <= byte_data; addr <= next(addr).
  - wr_en <= 1 only if addr < REG_COUNT; otherwise wr_en stays 0 and addr_err <= 1.
  - wr_en is high exactly one cycle, the cycle after byte_valid.
- Read advance, rd_ack in DATA: addr <= next(addr); no strobe. Read data is the register file's combinational lookup of addr.
- next(p), with mode sampled at the advance edge:
  - fixed: p.
  - linear: 0 if p >= REG_COUNT-1, else p+1.
  - bank: upper bits unchanged; low log2(BANK_SIZE) bits incremented modulo BANK_SIZE.
- Back-to-back byte_valid on consecutive cycles is supported; each cycle produces its own strobe and advance.
- busy = (state != IDLE), registered with the state.
- Reset mid-transfer aborts immediately; a pending wr_en is cancelled.

Decomposition:
- Shared package pwm_io_pkg:
  - mode encodings MODE_FIXED, MODE_LINEAR, MODE_BANK.
  - state enum IDLE/ADDR/DATA.
  - REG_COUNT default constant, also used by the register file.
- One natural sub-module, address_next_calc: combinational next(p) from p and mode, parametrised by ADDR_WIDTH/REG_COUNT/BANK_SIZE. It is reused by the register file's read-prefetch logic.

Test Plan:
- Reset: hold _RST low mid-transfer with byte_valid pulsing -> all outputs at reset values. After release, the first byte with no start produces no strobe and addr stays 0.
- Linear write, mode=01: start, byte 0x1E, bytes 0xAA, 0xBB, 0xCC -> strobes (0x1E,0xAA), (0x1F,0xBB), (0x00,0xCC), each one cycle after its byte_valid; addr ends at 0x01; addr_err=0.
- Bank wrap, mode=10: start, byte 0x0E, four data bytes -> wr_addr 0x0E, 0x0F, 0x08, 0x09. Fixed mode=00, same stimulus -> wr_addr 0x0E four times.
- Out of range, REG_COUNT=32: start, byte 0x25, data 0x55 -> addr=0x25, addr_err=1, no wr_en. A following start clears addr_err.
- Repeated-start read: start, byte 0x05, start, rd_ack x3, stop -> addr 0x05, then 0x06, 0x07, 0x08; state IDLE after stop; addr holds 0x08.
- Collisions: start and byte_valid in the same cycle -> byte dropped, state ADDR. byte_valid and rd_ack together in DATA -> one strobe, pointer advances by exactly one.

Source files
------------

// File: rtl/pwm_io_pkg.sv
// Shared encodings for the PWM IO expander serial-slave front end and register file.
package pwm_io_pkg;

    localparam logic [1:0] MODE_FIXED  = 2'b00;
    localparam logic [1:0] MODE_LINEAR = 2'b01;
    localparam logic [1:0] MODE_BANK   = 2'b10;

    localparam int REG_COUNT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/address_next_calc.sv
// Combinational pointer advance: fixed, linear wrap at REG_COUNT, or wrap inside a BANK_SIZE window.
// Zero latency; no flow control.
module address_next_calc
    import pwm_io_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_COUNT  = REG_COUNT_DEF,
    parameter int BANK_SIZE  = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_ptr,
    input  logic [1:0]            i_mode,
    output logic [ADDR_WIDTH-1:0] o_next
);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BANK_SIZE - 1);

    logic [ADDR_WIDTH-1:0] w_inc;
    logic                  w_at_last;

    assign w_inc     = i_ptr + ADDR_WIDTH'(1);
    assign w_at_last = 32'(i_ptr) >= 32'(REG_COUNT - 1);

    always_comb begin
        o_next = i_ptr;
        case (i_mode)
            MODE_LINEAR: o_next = w_at_last ? '0 : w_inc;
            // Bank window is a power of two, so masking keeps the upper bits and wraps the low ones.
            MODE_BANK:   o_next = (i_ptr & ~LOW_MASK) | (w_inc & LOW_MASK);
            default:     o_next = i_ptr;
        endcase
    end

endmodule

// File: rtl/register_address_pointer.sv
// Register-address pointer: first byte of a transfer loads the pointer, later bytes strobe writes and advance it.
// Write strobe one cycle after byte_valid; no backpressure, every accepted event is consumed in its cycle.
module register_address_pointer
    import pwm_io_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_COUNT  = REG_COUNT_DEF,
    parameter int BANK_SIZE  = 8
) (
    input  logic                  CLK,
    input  logic                  _RST,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  rd_ack,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  addr_err,
    output logic                  busy
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_err;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic [7:0]            w_wr_data_nxt;
    logic                  w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_ptr_adv;
    logic                  w_in_range;
    logic                  w_byte_oor;

    address_next_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .BANK_SIZE  (BANK_SIZE)
    ) u_next (
        .i_ptr  (r_addr),
        .i_mode (mode),
        .o_next (w_ptr_adv)
    );

    assign w_in_range = 32'(r_addr) < 32'(REG_COUNT);
    // Range check uses the whole byte so truncated high bits still flag an error.
    assign w_byte_oor = 32'(byte_data) >= 32'(REG_COUNT);

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_err_nxt     = r_err;
        if (start) begin
            w_state_nxt = ADDR;
            w_err_nxt   = 1'b0;
        end else if (stop) begin
            w_state_nxt = IDLE;
        end else if (byte_valid && r_state == ADDR) begin
            w_addr_nxt  = byte_data[ADDR_WIDTH-1:0];
            w_err_nxt   = w_byte_oor;
            w_state_nxt = DATA;
        end else if (byte_valid && r_state == DATA) begin
            w_wr_addr_nxt = r_addr;
            w_wr_data_nxt = byte_data;
            w_addr_nxt    = w_ptr_adv;
            if (w_in_range) begin
                w_wr_en_nxt = 1'b1;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (rd_ack && r_state != IDLE) begin
            // Reads after a repeated start advance from the retained pointer.
            w_addr_nxt = w_ptr_adv;
        end
    end

    assign addr     = r_addr;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign addr_err = r_err;
    assign busy     = r_busy;

endmodule

// File: tb/tb_register_address_pointer.sv
// Directed and randomized checks of register_address_pointer against an arithmetic reference model.
module tb_register_address_pointer;

    localparam int AW = 8;
    localparam int RC = 32;
    localparam int BS = 8;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          rd_ack = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          addr_err;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 idle, 1 waiting for address, 2 data phase.
    int m_state, m_addr, m_wr_en, m_wr_addr, m_wr_data, m_err;

    register_address_pointer #(.ADDR_WIDTH(AW), .REG_COUNT(RC), .BANK_SIZE(BS)) dut (
        .CLK        (CLK),
        ._RST       (rst_n),
        .start      (start),
        .stop       (stop),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .rd_ack     (rd_ack),
        .mode       (mode),
        .addr       (addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    function automatic int m_next(input int p, input int md);
        case (md)
            1:       return (p >= RC - 1) ? 0 : p + 1;
            2:       return (p / BS) * BS + ((p + 1) % BS);
            default: return p;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_addr = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_err = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit bv, input int d, input bit ack, input int md);
        m_wr_en = 0;
        if (s) begin
            m_state = 1; m_err = 0;
        end else if (p) begin
            m_state = 0;
        end else if (bv && m_state == 1) begin
            m_addr = d % (1 << AW); m_err = (d >= RC) ? 1 : 0; m_state = 2;
        end else if (bv && m_state == 2) begin
            m_wr_addr = m_addr; m_wr_data = d;
            if (m_addr < RC) m_wr_en = 1; else m_err = 1;
            m_addr = m_next(m_addr, md);
        end else if (ack && m_state != 0) begin
            m_addr = m_next(m_addr, md);
        end
    endtask

    // One clock cycle of stimulus; outputs are stable 1 time unit after the edge on return.
    task automatic cyc(input bit s, input bit p, input bit bv, input logic [7:0] d, input bit ack, input logic [1:0] md);
        start = s; stop = p; byte_valid = bv; byte_data = d; rd_ack = ack; mode = md;
        @(posedge CLK);
        if (!rst_n) model_reset();
        else model_step(s, p, bv, int'(d), ack, int'(md));
        #1;
        start = 0; stop = 0; byte_valid = 0; rd_ack = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_tests++;
        if ({addr, wr_en, wr_addr, wr_data, addr_err, busy} !== '0) begin
            n_fail++; $display("FAIL reset_initial: outputs=%h required all zero", {addr, wr_en, wr_addr, wr_data, addr_err, busy});
        end
        @(negedge CLK); rst_n = 1'b1;
        cyc(1, 0, 0, 8'h00, 0, 2'b01);
        cyc(0, 0, 1, 8'h03, 0, 2'b01);
        cyc(0, 0, 1, 8'h44, 0, 2'b01);
        n_tests++;
        if (wr_en !== 1'b1) begin
            n_fail++; $display("FAIL reset_prewrite: wr_en=%b required 1", wr_en);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: wr_en=%b busy=%b required 0 0", wr_en, busy);
        end
        cyc(0, 0, 1, 8'h11, 0, 2'b01);
        cyc(1, 0, 1, 8'h22, 0, 2'b01);
        n_tests++;
        if ({addr, wr_en, wr_addr, wr_data, addr_err, busy} !== '0) begin
            n_fail++; $display("FAIL reset_held: outputs=%h required all zero", {addr, wr_en, wr_addr, wr_data, addr_err, busy});
        end
        #2; rst_n = 1'b1;
        cyc(0, 0, 1, 8'h12, 0, 2'b01);
        n_tests++;
        if (wr_en !== 1'b0 || addr !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_start: wr_en=%b addr=%h busy=%b required 0 00 0", wr_en, addr, busy);
        end
    endtask

    task automatic test_linear();
        logic [7:0] dat [3];
        logic [7:0] exp_a [3];
        dat = '{8'hAA, 8'hBB, 8'hCC};
        exp_a = '{8'h1E, 8'h1F, 8'h00};
        cyc(1, 0, 0, 8'h00, 0, 2'b01);
        cyc(0, 0, 1, 8'h1E, 0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, dat[i], 0, 2'b01);
            n_tests++;
            if (wr_en !== 1'b1 || wr_addr !== exp_a[i] || wr_data !== dat[i]) begin
                n_fail++; $display("FAIL linear_strobe%0d: en=%b addr=%h data=%h required 1 %h %h", i, wr_en, wr_addr, wr_data, exp_a[i], dat[i]);
            end
        end
        cyc(0, 0, 0, 8'h00, 0, 2'b01);
        n_tests++;
        if (wr_en !== 1'b0 || addr !== 8'h01 || addr_err !== 1'b0) begin
            n_fail++; $display("FAIL linear_end: en=%b addr=%h err=%b required 0 01 0", wr_en, addr, addr_err);
        end
        cyc(0, 1, 0, 8'h00, 0, 2'b01);
    endtask

    task automatic test_bank_fixed();
        logic [7:0] exp_b [4];
        exp_b = '{8'h0E, 8'h0F, 8'h08, 8'h09};
        for (int md = 2; md >= 0; md -= 2) begin
            cyc(1, 0, 0, 8'h00, 0, 2'(md));
            cyc(0, 0, 1, 8'h0E, 0, 2'(md));
            for (int i = 0; i < 4; i++) begin
                cyc(0, 0, 1, 8'(8'h60 + i), 0, 2'(md));
                n_tests++;
                if (wr_en !== 1'b1 || wr_addr !== ((md == 2) ? exp_b[i] : 8'h0E)) begin
                    n_fail++; $display("FAIL mode%0d_strobe%0d: en=%b addr=%h required 1 %h", md, i, wr_en, wr_addr, (md == 2) ? exp_b[i] : 8'h0E);
                end
            end
            cyc(0, 1, 0, 8'h00, 0, 2'(md));
        end
    endtask

    task automatic test_out_of_range();
        cyc(1, 0, 0, 8'h00, 0, 2'b00);
        cyc(0, 0, 1, 8'h25, 0, 2'b00);
        n_tests++;
        if (addr !== 8'h25 || addr_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_load: addr=%h err=%b required 25 1", addr, addr_err);
        end
        cyc(0, 0, 1, 8'h55, 0, 2'b00);
        n_tests++;
        if (wr_en !== 1'b0 || addr_err !== 1'b1 || addr !== 8'h25) begin
            n_fail++; $display("FAIL oor_write: en=%b err=%b addr=%h required 0 1 25", wr_en, addr_err, addr);
        end
        cyc(1, 0, 0, 8'h00, 0, 2'b00);
        n_tests++;
        if (addr_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL oor_clear: err=%b busy=%b required 0 1", addr_err, busy);
        end
        cyc(0, 1, 0, 8'h00, 0, 2'b00);
    endtask

    task automatic test_repeated_start_read();
        cyc(1, 0, 0, 8'h00, 0, 2'b01);
        cyc(0, 0, 1, 8'h05, 0, 2'b01);
        cyc(1, 0, 0, 8'h00, 0, 2'b01);
        n_tests++;
        if (addr !== 8'h05) begin
            n_fail++; $display("FAIL rd_retain: addr=%h required 05", addr);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 8'h00, 1, 2'b01);
            n_tests++;
            if (addr !== 8'(5 + i) || wr_en !== 1'b0) begin
                n_fail++; $display("FAIL rd_adv%0d: addr=%h en=%b required %h 0", i, addr, wr_en, 8'(5 + i));
            end
        end
        cyc(0, 1, 0, 8'h00, 0, 2'b01);
        cyc(0, 0, 0, 8'h00, 1, 2'b01);
        n_tests++;
        if (busy !== 1'b0 || addr !== 8'h08) begin
            n_fail++; $display("FAIL rd_stop: busy=%b addr=%h required 0 08", busy, addr);
        end
    endtask

    task automatic test_collisions();
        cyc(1, 0, 1, 8'h10, 0, 2'b01);
        n_tests++;
        if (busy !== 1'b1 || addr !== 8'h08 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL col_start_byte: busy=%b addr=%h en=%b required 1 08 0", busy, addr, wr_en);
        end
        cyc(0, 0, 1, 8'h10, 0, 2'b01);
        n_tests++;
        if (addr !== 8'h10) begin
            n_fail++; $display("FAIL col_addr_load: addr=%h required 10", addr);
        end
        cyc(0, 0, 1, 8'h77, 1, 2'b01);
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h10 || addr !== 8'h11) begin
            n_fail++; $display("FAIL col_byte_ack: en=%b waddr=%h addr=%h required 1 10 11", wr_en, wr_addr, addr);
        end
        cyc(0, 0, 0, 8'h00, 0, 2'b01);
        n_tests++;
        if (wr_en !== 1'b0 || addr !== 8'h11) begin
            n_fail++; $display("FAIL col_single: en=%b addr=%h required 0 11", wr_en, addr);
        end
        cyc(0, 1, 0, 8'h00, 0, 2'b01);
    endtask

    task automatic test_random();
        logic [AW-1:0] e_addr, e_waddr;
        logic [7:0]    e_wdata;
        bit s, p, bv, ack;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 11) == 0);
            p   = ($urandom_range(0, 13) == 0);
            bv  = ($urandom_range(0, 2) != 0);
            ack = ($urandom_range(0, 3) == 0);
            cyc(s, p, bv, 8'($urandom_range(0, 40)), ack, 2'($urandom_range(0, 3)));
            e_addr  = AW'(m_addr);
            e_waddr = AW'(m_wr_addr);
            e_wdata = 8'(m_wr_data);
            n_tests++;
            if (addr !== e_addr || wr_en !== (m_wr_en != 0) || wr_addr !== e_waddr || wr_data !== e_wdata
                || addr_err !== (m_err != 0) || busy !== (m_state != 0)) begin
                n_fail++;
                $display("FAIL random%0d: addr=%h en=%b waddr=%h wdata=%h err=%b busy=%b required %h %0d %h %h %0d %0d",
                         i, addr, wr_en, wr_addr, wr_data, addr_err, busy, e_addr, m_wr_en, e_waddr, e_wdata, m_err, m_state != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_bank_fixed();
        test_out_of_range();
        test_repeated_start_read();
        test_collisions();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
